// File: rtl/noc_pkg.sv
// Shared types and helpers for the NoC decoder/FIFO router slice.
// Widths here are the default router configuration; modules carry their own parameters.
package noc_pkg;

  localparam int FLIT_W   = 9;
  localparam int NOUT_DEF = 4;
  localparam int SEL_W    = $clog2(NOUT_DEF);

  typedef logic [FLIT_W-1:0] flit_t;
  typedef logic [SEL_W-1:0]  sel_t;

  // True when a select value names an existing output channel.
  function automatic logic sel_in_range(input int unsigned sel, input int unsigned nout);
    return sel < nout;
  endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Single-clock FIFO with registered full/empty flags and arbitrary (non power-of-2) depth.
// Push is refused while full, even if a pop happens in the same cycle.
module noc_sync_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [W-1:0]    mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CNTW-1:0] count;
  logic [CNTW-1:0] count_nxt;
  logic            full_q;
  logic            empty_q;
  logic            do_push;
  logic            do_pop;

  // Explicit wrap compare so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_push = push & ~full_q;
  assign do_pop  = pop & ~empty_q;

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop) begin
      count_nxt = count + CNTW'(1);
    end else if (!do_push && do_pop) begin
      count_nxt = count - CNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (do_push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      count   <= count_nxt;
      full_q  <= (count_nxt == CNTW'(DEPTH));
      empty_q <= (count_nxt == '0);
    end
  end

  // Storage carries no reset; the registered empty flag masks stale entries.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/decoder_n_fifo_router.sv
// Joins a data channel with a select channel and routes each token into a per-output FIFO.
// Out-of-range selects are consumed, discarded and counted in a saturating drop counter.
module decoder_n_fifo_router
  import noc_pkg::*;
#(
  parameter int W     = 9,
  parameter int NOUT  = 4,
  parameter int DEPTH = 2,
  parameter int SW    = $clog2(NOUT),
  parameter int CW    = 16
) (
  input  logic              CLK,
  input  logic              _RESET,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      in_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [SW-1:0]     s_data,
  output logic [NOUT-1:0]   out_valid,
  input  logic [NOUT-1:0]   out_ready,
  output logic [NOUT*W-1:0] out_data,
  output logic [CW-1:0]     drop_count
);

  // Handshake: a token moves on a channel in any cycle where its valid and ready are both
  // high. The In and S channels form one join: both ready outputs equal fire, so the data
  // and select tokens are consumed together or not at all. Ready depends only on the peer
  // valid and registered FIFO full flags, never on out_ready.

  logic [NOUT-1:0]      full;
  logic [NOUT-1:0]      empty;
  logic [NOUT-1:0]      push;
  logic [(1<<SW)-1:0]   full_pad;
  logic                 oor;
  logic                 sel_full;
  logic                 fire;

  // Select codes with no output read as full; oor bypasses that flag anyway.
  always_comb begin
    full_pad             = '1;
    full_pad[NOUT-1:0]   = full;
  end

  assign oor      = ~sel_in_range(int'(s_data), NOUT);
  assign sel_full = full_pad[s_data];
  assign fire     = _RESET & in_valid & s_valid & (oor | ~sel_full);
  assign in_ready = fire;
  assign s_ready  = fire;

  for (genvar i = 0; i < NOUT; i++) begin : g_out
    logic [W-1:0] head;

    assign push[i] = fire & ~oor & (s_data == SW'(i));

    noc_sync_fifo #(
      .W     (W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk       (CLK),
      .rst_n     (_RESET),
      .push      (push[i]),
      .push_data (in_data),
      .pop       (out_ready[i]),
      .full      (full[i]),
      .empty     (empty[i]),
      .head      (head)
    );

    assign out_data[i*W +: W] = head;
  end

  assign out_valid = ~empty;

  always_ff @(posedge CLK) begin
    if (!_RESET) begin
      drop_count <= '0;
    end else if (fire && oor && (drop_count != '1)) begin
      drop_count <= drop_count + CW'(1);
    end
  end

endmodule
